// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: operand/op issue channel and result channel.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;

  // Issue side drives operands and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  // ALU side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpAnd   = 4'h3;
  localparam logic [3:0] OpOr    = 4'h4;
  localparam logic [3:0] OpXor   = 4'h5;
  localparam logic [3:0] OpNot   = 4'h6;
  localparam logic [3:0] OpSll   = 4'h7;
  localparam logic [3:0] OpSrl   = 4'h8;
  localparam logic [3:0] OpSra   = 4'h9;
  localparam logic [3:0] OpRol   = 4'hA;
  localparam logic [3:0] OpMul   = 4'hB;
  localparam logic [3:0] OpMulhu = 4'hC;
  localparam logic [3:0] OpDivu  = 4'hD;
  localparam logic [3:0] OpRemu  = 4'hE;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // {high, low} working accumulator
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 is_iter;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step_next;

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   res;
    sh  = b[SHW-1:0];
    // Rotate via the upper half of a doubled, left-shifted copy; amount 0 gives A.
    dbl = {a, a} << sh;
    res = '0;
    case (op)
      OpAdd:   res = a + b;
      OpSub:   res = a - b;
      OpAnd:   res = a & b;
      OpOr:    res = a | b;
      OpXor:   res = a ^ b;
      OpNot:   res = ~a;
      OpSll:   res = a << sh;
      OpSrl:   res = a >> sh;
      OpSra:   res = $signed(a) >>> sh;
      OpRol:   res = dbl[2*WIDTH-1:WIDTH];
      default: res = '0;
    endcase
    return res;
  endfunction

  assign accept  = bus.in_valid & bus.in_ready;
  assign is_iter = (bus.in_op >= OpMul) && (bus.in_op <= OpRemu);

  assign bus.in_ready   = rst_n & ((state_q == StIdle) | ((state_q == StDone) & bus.out_ready));
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_result = result_q;
  assign bus.out_err    = err_q;

  // One iteration of multiply (add multiplicand on LSB, shift right) or
  // restoring divide (shift left, trial-subtract divisor, shift in quotient bit).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, opnd_q};
    div_next  = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step_next = ((op_q == OpDivu) || (op_q == OpRemu)) ? div_next : mul_next;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone && bus.out_ready) state_d = StIdle;
        if (accept) begin
          op_d = bus.in_op;
          if (is_iter) begin
            state_d = StRun;
            cnt_d   = '0;
            if ((bus.in_op == OpDivu) || (bus.in_op == OpRemu)) begin
              acc_d  = {{WIDTH{1'b0}}, bus.in_a};
              opnd_d = bus.in_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, bus.in_b};
              opnd_d = bus.in_a;
            end
          end else begin
            state_d  = StDone;
            result_d = single_op(bus.in_op, bus.in_a, bus.in_b);
            err_d    = (bus.in_op == 4'h0) || (bus.in_op == 4'hF);
          end
        end
      end
      StRun: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          cnt_d    = '0;
          err_d    = 1'b0;
          // MULHU/REMU take the high half, MUL/DIVU the low half.
          result_d = ((op_q == OpMulhu) || (op_q == OpRemu)) ? step_next[2*WIDTH-1:WIDTH]
                                                             : step_next[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
endmodule
